// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - two-requester arbiter in front of APB_Master (tie-break: ARB_ROUND_ROBIN_EN)
module apb_req_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_transfer,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_write,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_transfer,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_write,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        transfer,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic        write,
    input  logic        ready,
    input  logic [31:0] rdata,
    output logic        busy,
    output logic        grant
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]  r_state;
    logic        r_pend0, r_pend1;
    logic [31:0] r_addr0, r_addr1, r_wdata0, r_wdata1;
    logic        r_write0, r_write1;
    logic        r_grant;
    logic [31:0] r_addr, r_wdata;
    logic        r_write;
    logic        r_m0_ready, r_m1_ready;
    logic [31:0] r_m0_rdata, r_m1_rdata;
`ifdef ARB_ROUND_ROBIN_EN
    logic        r_last;
`endif

    logic        w_winner;
    logic        w_done0, w_done1;

    // Completion of the downstream access, steered to the current owner
    assign w_done0 = (r_state == ST_WAIT) && ready && !r_grant;
    assign w_done1 = (r_state == ST_WAIT) && ready &&  r_grant;

    // Pick the winner among pending requests; only meaningful when one is pending
    always_comb begin
        w_winner = 1'b0;
        if (r_pend0 && r_pend1) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_winner = ~r_last;
`else
            w_winner = 1'b0;
`endif
        end else begin
            w_winner = r_pend1;
        end
    end

    // Requester 0 request register: latch first pulse, drop repeats until completion
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend0  <= 1'b0;
            r_addr0  <= 32'd0;
            r_wdata0 <= 32'd0;
            r_write0 <= 1'b0;
        end else if (w_done0) begin
            r_pend0 <= 1'b0;
        end else if (m0_transfer && !r_pend0) begin
            r_pend0  <= 1'b1;
            r_addr0  <= m0_addr;
            r_wdata0 <= m0_wdata;
            r_write0 <= m0_write;
        end
    end

    // Requester 1 request register: same policy as requester 0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend1  <= 1'b0;
            r_addr1  <= 32'd0;
            r_wdata1 <= 32'd0;
            r_write1 <= 1'b0;
        end else if (w_done1) begin
            r_pend1 <= 1'b0;
        end else if (m1_transfer && !r_pend1) begin
            r_pend1  <= 1'b1;
            r_addr1  <= m1_addr;
            r_wdata1 <= m1_wdata;
            r_write1 <= m1_write;
        end
    end

    // Arbitration FSM: grant in IDLE, one-cycle issue, hold request until ready
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_grant <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_write <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last  <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_pend0 || r_pend1) begin
                        r_grant <= w_winner;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last  <= w_winner;
`endif
                        r_addr  <= w_winner ? r_addr1  : r_addr0;
                        r_wdata <= w_winner ? r_wdata1 : r_wdata0;
                        r_write <= w_winner ? r_write1 : r_write0;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: r_state <= ST_WAIT;
                ST_WAIT:  if (ready) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Return path: one-cycle ready pulse and rdata capture for the owner only
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m0_ready <= 1'b0;
            r_m1_ready <= 1'b0;
            r_m0_rdata <= 32'd0;
            r_m1_rdata <= 32'd0;
        end else begin
            r_m0_ready <= w_done0;
            r_m1_ready <= w_done1;
            if (w_done0) r_m0_rdata <= rdata;
            if (w_done1) r_m1_rdata <= rdata;
        end
    end

    assign transfer = (r_state == ST_ISSUE);
    assign busy     = (r_state != ST_IDLE);
    assign grant    = r_grant;
    assign addr     = r_addr;
    assign wdata    = r_wdata;
    assign write    = r_write;
    assign m0_ready = r_m0_ready;
    assign m1_ready = r_m1_ready;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;

endmodule
